// File: rtl/bsg_cache_nb_rmq_scheduler_if.sv
// Handshake bundle between the non-blocking cache miss pipeline, the read miss
// queue and the scheduler. The scheduler uses the slave modport; the
// environment driving it uses master.
interface bsg_cache_nb_rmq_scheduler_if #(
  parameter int unsigned mshr_els_p = 4,
  parameter int unsigned lg_mshr_lp = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
);
  logic                  fill_done_v_i;
  logic [lg_mshr_lp-1:0] fill_done_id_i;
  logic [mshr_els_p-1:0] rmq_v_i;
  logic [mshr_els_p-1:0] rmq_ready_i;
  logic                  enq_v_i;
  logic [lg_mshr_lp-1:0] enq_id_i;
  logic                  enq_ready_o;
  logic                  rmq_v_o;
  logic                  rmq_write_not_read_o;
  logic [lg_mshr_lp-1:0] rmq_mshr_id_o;
  logic                  rmq_read_done_i;
  logic                  rmq_yumi_o;
  logic                  serve_v_o;
  logic [lg_mshr_lp-1:0] serve_id_o;
  logic                  serve_yumi_i;
  logic                  release_v_o;
  logic [lg_mshr_lp-1:0] release_id_o;
  logic [mshr_els_p-1:0] pending_o;
  logic                  busy_o;

  modport slave (
    input  fill_done_v_i, fill_done_id_i, rmq_v_i, rmq_ready_i, enq_v_i, enq_id_i,
    input  rmq_read_done_i, serve_yumi_i,
    output enq_ready_o, rmq_v_o, rmq_write_not_read_o, rmq_mshr_id_o, rmq_yumi_o,
    output serve_v_o, serve_id_o, release_v_o, release_id_o, pending_o, busy_o
  );

  modport master (
    output fill_done_v_i, fill_done_id_i, rmq_v_i, rmq_ready_i, enq_v_i, enq_id_i,
    output rmq_read_done_i, serve_yumi_i,
    input  enq_ready_o, rmq_v_o, rmq_write_not_read_o, rmq_mshr_id_o, rmq_yumi_o,
    input  serve_v_o, serve_id_o, release_v_o, release_id_o, pending_o, busy_o
  );
endinterface

// File: rtl/bsg_cache_nb_rmq_scheduler.sv
// Read miss queue scheduler for the non-blocking cache. Arbitrates between
// appending new read misses to the queue and draining the queue of an MSHR
// whose block fill has completed, then signals when that MSHR may be freed.
// Optional starvation guard: define BSG_CACHE_NB_RMQ_STARVE_GUARD_EN.
module bsg_cache_nb_rmq_scheduler #(
  parameter int unsigned mshr_els_p     = 4,
  parameter int unsigned starve_limit_p = 8,
  localparam int unsigned lg_mshr_lp    = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bsg_cache_nb_rmq_scheduler_if.slave bus
);

  if (starve_limit_p < 1) begin : g_bad_limit
    $error("starve_limit_p must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e                r_state, w_state_d;
  logic [mshr_els_p-1:0] r_pending, w_pending_d;
  logic [lg_mshr_lp-1:0] r_ptr, w_ptr_d;
  logic [lg_mshr_lp-1:0] r_gid, w_gid_d;
  logic                  r_release_v;
  logic [lg_mshr_lp-1:0] r_release_id;

  logic                  w_any_pend;
  logic                  w_enq_eligible;
  logic                  w_serve_wins;
  logic                  w_starve_full;
  logic                  w_grant_found;
  logic [lg_mshr_lp-1:0] w_grant_id;
  logic [lg_mshr_lp-1:0] w_scan_idx;
  logic [lg_mshr_lp-1:0] w_ptr_next;
  logic                  w_grant_v;
  logic                  w_retire_v;
  logic [lg_mshr_lp-1:0] w_retire_id;
  logic                  w_enq_ready;
  logic                  w_rmq_v;
  logic                  w_wnr;
  logic [lg_mshr_lp-1:0] w_rmq_id;
  logic                  w_serve_v;
  logic [lg_mshr_lp-1:0] w_serve_id;
  logic                  w_yumi;

  assign w_any_pend = |r_pending;

  // An enqueue only competes with service when it could actually be accepted;
  // a held-off enqueue (target still pending) must not block the retirement
  // it is waiting for.
  assign w_enq_eligible = bus.enq_v_i & bus.rmq_ready_i[bus.enq_id_i]
                        & ~r_pending[bus.enq_id_i];
  assign w_serve_wins   = w_any_pend & (~w_enq_eligible | w_starve_full);

  // Round-robin pick: first pending MSHR at or after the pointer, wrapping.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_scan_idx    = '0;
    for (int unsigned k = 0; k < mshr_els_p; k++) begin
      w_scan_idx = lg_mshr_lp'((32'(r_ptr) + k) % mshr_els_p);
      if (!w_grant_found && r_pending[w_scan_idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_scan_idx;
      end
    end
    w_ptr_next = lg_mshr_lp'((32'(w_grant_id) + 32'd1) % mshr_els_p);
  end

  // Next state and queue/consumer control.
  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_gid_d     = r_gid;
    w_grant_v   = 1'b0;
    w_retire_v  = 1'b0;
    w_retire_id = '0;
    w_enq_ready = 1'b0;
    w_rmq_v     = 1'b0;
    w_wnr       = 1'b0;
    w_rmq_id    = '0;
    w_serve_v   = 1'b0;
    w_serve_id  = '0;
    w_yumi      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_rmq_id = bus.enq_id_i;
        if (w_serve_wins) begin
          w_grant_v = 1'b1;
          w_ptr_d   = w_ptr_next;
          w_rmq_id  = w_grant_id;
          if (bus.rmq_v_i[w_grant_id]) begin
            w_rmq_v   = 1'b1;
            w_gid_d   = w_grant_id;
            w_state_d = StServe;
          end else begin
            // Nothing queued for this MSHR: free it without touching the queue.
            w_retire_v  = 1'b1;
            w_retire_id = w_grant_id;
          end
        end else if (w_enq_eligible) begin
          w_enq_ready = 1'b1;
          w_rmq_v     = 1'b1;
          w_wnr       = 1'b1;
        end
      end
      StServe: begin
        w_serve_v  = 1'b1;
        w_serve_id = r_gid;
        w_yumi     = bus.serve_yumi_i;
        w_rmq_id   = r_gid;
        if (bus.rmq_read_done_i) begin
          w_retire_v  = 1'b1;
          w_retire_id = r_gid;
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pending mask: a new fill completion beats a same-cycle retirement.
  always_comb begin
    w_pending_d = r_pending;
    if (w_retire_v) w_pending_d[w_retire_id] = 1'b0;
    if (bus.fill_done_v_i) w_pending_d[bus.fill_done_id_i] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= StIdle;
      r_pending    <= '0;
      r_ptr        <= '0;
      r_gid        <= '0;
      r_release_v  <= 1'b0;
      r_release_id <= '0;
    end else begin
      r_state      <= w_state_d;
      r_pending    <= w_pending_d;
      r_ptr        <= w_ptr_d;
      r_gid        <= w_gid_d;
      r_release_v  <= w_retire_v;
      r_release_id <= w_retire_id;
    end
  end

`ifdef BSG_CACHE_NB_RMQ_STARVE_GUARD_EN
  localparam int unsigned cnt_w_lp = $clog2(starve_limit_p + 1);

  logic [cnt_w_lp-1:0] r_starve_cnt, w_starve_cnt_d;

  assign w_starve_full = (r_starve_cnt == cnt_w_lp'(starve_limit_p));

  // Count idle cycles where an enqueue beat waiting service; any grant clears.
  always_comb begin
    w_starve_cnt_d = r_starve_cnt;
    if (w_grant_v || w_retire_v) begin
      w_starve_cnt_d = '0;
    end else if (r_state == StIdle && w_any_pend && w_enq_eligible && !w_starve_full) begin
      w_starve_cnt_d = r_starve_cnt + cnt_w_lp'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_starve_cnt <= '0;
    else            r_starve_cnt <= w_starve_cnt_d;
  end
`else
  assign w_starve_full = 1'b0;
`endif

  // Combinational outputs are forced low while reset is held.
  assign bus.enq_ready_o          = reset_n_i & w_enq_ready;
  assign bus.rmq_v_o              = reset_n_i & w_rmq_v;
  assign bus.rmq_write_not_read_o = reset_n_i & w_wnr;
  assign bus.rmq_mshr_id_o        = reset_n_i ? w_rmq_id : '0;
  assign bus.rmq_yumi_o           = reset_n_i & w_yumi;
  assign bus.serve_v_o            = reset_n_i & w_serve_v;
  assign bus.serve_id_o           = reset_n_i ? w_serve_id : '0;
  assign bus.release_v_o          = r_release_v;
  assign bus.release_id_o         = r_release_id;
  assign bus.pending_o            = r_pending;
  assign bus.busy_o               = (r_state == StServe);

endmodule

// File: tb/tb_bsg_cache_nb_rmq_scheduler.sv
// Self-checking bench for bsg_cache_nb_rmq_scheduler: directed scenarios plus
// a randomized run against a queue-level reference model.
module tb_bsg_cache_nb_rmq_scheduler;
  localparam int N  = 4;
  localparam int LG = 2;
  localparam int L  = 8;
  localparam int QD = 3;
`ifdef BSG_CACHE_NB_RMQ_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bsg_cache_nb_rmq_scheduler_if #(.mshr_els_p(N)) bus ();

  bsg_cache_nb_rmq_scheduler #(
    .mshr_els_p    (N),
    .starve_limit_p(L)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  function automatic logic [16:0] outs_vec();
    return {bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_yumi_o,
            bus.serve_v_o, bus.release_v_o, bus.busy_o, bus.pending_o,
            bus.rmq_mshr_id_o, bus.serve_id_o, bus.release_id_o};
  endfunction

  task automatic drive_idle();
    bus.fill_done_v_i   = 1'b0;
    bus.fill_done_id_i  = '0;
    bus.rmq_v_i         = '0;
    bus.rmq_ready_i     = '1;
    bus.enq_v_i         = 1'b0;
    bus.enq_id_i        = '0;
    bus.rmq_read_done_i = 1'b0;
    bus.serve_yumi_i    = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] v;
    reset_n = 1'b0;
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd2;
    bus.rmq_v_i = '1; bus.rmq_ready_i = '1;
    bus.enq_v_i = 1'b1; bus.enq_id_i = 2'd1;
    bus.rmq_read_done_i = 1'b1; bus.serve_yumi_i = 1'b1;
    #2;
    v = outs_vec();
    n_tests++;
    if (v !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", v);
    end
    next_cycle();
    n_tests++;
    if (bus.pending_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pending_hold: got %b want 0000", bus.pending_o);
    end
    drive_idle();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_serve();
    do_reset();
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd2;
    bus.rmq_v_i = 4'b0100; bus.serve_yumi_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.rmq_v_o, bus.pending_o} !== 5'b0_0000) begin
      n_fail++; $display("FAIL single_pre: got %b want 00000", {bus.rmq_v_o, bus.pending_o});
    end
    next_cycle();
    bus.fill_done_v_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o, bus.busy_o, bus.pending_o}
        !== {1'b1, 1'b0, 2'd2, 1'b0, 4'b0100}) begin
      n_fail++; $display("FAIL single_grant: got %b want 1010_0_0100",
        {bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o, bus.busy_o, bus.pending_o});
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      bus.rmq_read_done_i = (i == 2);
      bus.enq_v_i = 1'b1; bus.enq_id_i = 2'd0;
      @(negedge clk);
      n_tests++;
      if ({bus.serve_v_o, bus.serve_id_o, bus.rmq_yumi_o, bus.rmq_v_o, bus.enq_ready_o,
           bus.busy_o} !== {1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL single_serve_cycle%0d: got %b want 1101001", i,
          {bus.serve_v_o, bus.serve_id_o, bus.rmq_yumi_o, bus.rmq_v_o, bus.enq_ready_o,
           bus.busy_o});
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    n_tests++;
    if ({bus.release_v_o, bus.release_id_o, bus.pending_o, bus.busy_o, bus.serve_v_o}
        !== {1'b1, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_release: got %b want 110000000",
        {bus.release_v_o, bus.release_id_o, bus.pending_o, bus.busy_o, bus.serve_v_o});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (bus.release_v_o !== 1'b0) begin
      n_fail++; $display("FAIL single_release_once: got %b want 0", bus.release_v_o);
    end
  endtask

  task automatic test_rr_order();
    int exp_ids [5];
    int got_q   [$];
    int fills_a [3];
    int fills_b [2];
    int acc;
    exp_ids = '{0, 1, 3, 0, 3};
    fills_a = '{0, 1, 3};
    fills_b = '{3, 0};
    do_reset();
    bus.rmq_v_i = 4'b1111; bus.serve_yumi_i = 1'b1; bus.rmq_read_done_i = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      bus.enq_v_i = 1'b1; bus.enq_id_i = 2'd2;
      acc = 0;
      for (int i = 0; i < 3 - phase; i++) begin
        bus.fill_done_v_i  = 1'b1;
        bus.fill_done_id_i = (phase == 0) ? 2'(fills_a[i]) : 2'(fills_b[i]);
        @(negedge clk);
        if (bus.enq_ready_o === 1'b1) acc++;
        next_cycle();
      end
      bus.fill_done_v_i = 1'b0;
      n_tests++;
      if (acc != 3 - phase) begin
        n_fail++; $display("FAIL rr_enq_window%0d: got %0d accepts want %0d", phase, acc,
          3 - phase);
      end
      bus.enq_v_i = 1'b0;
      for (int c = 0; c < 40 && got_q.size() < ((phase == 0) ? 3 : 5); c++) begin
        @(negedge clk);
        if (bus.release_v_o === 1'b1) got_q.push_back(int'(bus.release_id_o));
        next_cycle();
      end
    end
    n_tests++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL rr_release_count: got %0d want 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_tests++;
      if (got_q[i] != exp_ids[i]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got id %0d want %0d", i, got_q[i], exp_ids[i]);
      end
    end
  endtask

  task automatic test_empty_retire();
    do_reset();
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd1;
    next_cycle();
    bus.fill_done_v_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.rmq_v_o, bus.busy_o, bus.serve_v_o, bus.release_v_o, bus.pending_o}
        !== {4'b0000, 4'b0010}) begin
      n_fail++; $display("FAIL empty_grant: got %b want 00000010",
        {bus.rmq_v_o, bus.busy_o, bus.serve_v_o, bus.release_v_o, bus.pending_o});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({bus.release_v_o, bus.release_id_o, bus.busy_o, bus.pending_o}
        !== {1'b1, 2'd1, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL empty_release: got %b want 10100000",
        {bus.release_v_o, bus.release_id_o, bus.busy_o, bus.pending_o});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (bus.release_v_o !== 1'b0) begin
      n_fail++; $display("FAIL empty_release_once: got %b want 0", bus.release_v_o);
    end
  endtask

  task automatic test_enq_holdoff();
    do_reset();
    bus.rmq_v_i = 4'b0100;
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd2;
    next_cycle();
    bus.fill_done_v_i = 1'b0;
    bus.enq_v_i = 1'b1; bus.enq_id_i = 2'd2;
    @(negedge clk);
    n_tests++;
    if ({bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o}
        !== {1'b0, 1'b1, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL holdoff_grant: got %b want 01010",
        {bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o});
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      bus.rmq_read_done_i = (i == 3);
      @(negedge clk);
      n_tests++;
      if (bus.enq_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL holdoff_serve%0d: got enq_ready %b want 0", i,
          bus.enq_ready_o);
      end
      next_cycle();
    end
    bus.rmq_read_done_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.release_v_o, bus.release_id_o, bus.enq_ready_o, bus.rmq_v_o,
         bus.rmq_write_not_read_o, bus.rmq_mshr_id_o} !== {1'b1, 2'd2, 3'b111, 2'd2}) begin
      n_fail++; $display("FAIL holdoff_accept: got %b want 11011110",
        {bus.release_v_o, bus.release_id_o, bus.enq_ready_o, bus.rmq_v_o,
         bus.rmq_write_not_read_o, bus.rmq_mshr_id_o});
    end
    next_cycle();
  endtask

  task automatic test_enq_priority();
    do_reset();
    bus.rmq_v_i = 4'b0001;
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd0;
    bus.enq_v_i = 1'b1; bus.enq_id_i = 2'd1;
    next_cycle();
    bus.fill_done_v_i = 1'b0;
    for (int i = 0; i < (Guard ? L : 12); i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o}
          !== {3'b111, 2'd1}) begin
        n_fail++; $display("FAIL enq_priority%0d: got %b want 11101", i,
          {bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o});
      end
      next_cycle();
    end
    if (Guard) begin
      @(negedge clk);
      n_tests++;
      if ({bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o}
          !== {3'b010, 2'd0}) begin
        n_fail++; $display("FAIL starve_serve: got %b want 01000",
          {bus.enq_ready_o, bus.rmq_v_o, bus.rmq_write_not_read_o, bus.rmq_mshr_id_o});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_serve();
    logic [16:0] v;
    do_reset();
    bus.rmq_v_i = 4'b0010;
    bus.fill_done_v_i = 1'b1; bus.fill_done_id_i = 2'd1;
    next_cycle();
    bus.fill_done_v_i = 1'b0;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({bus.busy_o, bus.serve_v_o} !== 2'b11) begin
      n_fail++; $display("FAIL midreset_in_serve: got %b want 11", {bus.busy_o, bus.serve_v_o});
    end
    #2;
    bus.rmq_read_done_i = 1'b1; bus.serve_yumi_i = 1'b1;
    reset_n = 1'b0;
    #1;
    v = outs_vec();
    n_tests++;
    if (v !== 17'd0) begin
      n_fail++; $display("FAIL midreset_async: got %h want 0", v);
    end
    next_cycle();
    drive_idle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.release_v_o, bus.busy_o, bus.pending_o} !== 6'd0) begin
        n_fail++; $display("FAIL midreset_after%0d: got %b want 000000", i,
          {bus.release_v_o, bus.busy_o, bus.pending_o});
      end
      next_cycle();
    end
  endtask

  task automatic test_random(input int cycles);
    bit          m_pend [N];
    int          q_cnt  [N];
    int          m_ptr, m_serving, m_rel_id, m_cnt, g, retire, prints;
    bit          m_rel_v, any, elig, sw, yumi;
    logic        e_enq_ready, e_rmq_v, e_wnr, e_serve_v, e_yumi, e_busy, id_care;
    logic [1:0]  e_id, e_serve_id;
    logic [N-1:0] pv;
    logic [16:0] exp_v, act_v;
    do_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; q_cnt[i] = 0; end
    m_ptr = 0; m_serving = -1; m_rel_v = 1'b0; m_rel_id = 0; m_cnt = 0; prints = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.fill_done_v_i  = ($urandom_range(0, 3) == 0);
      bus.fill_done_id_i = 2'($urandom_range(0, N - 1));
      bus.enq_v_i        = 1'($urandom_range(0, 1));
      bus.enq_id_i       = 2'($urandom_range(0, N - 1));
      yumi               = 1'($urandom_range(0, 1));
      bus.serve_yumi_i   = yumi;
      for (int i = 0; i < N; i++) begin
        bus.rmq_v_i[i]     = (q_cnt[i] > 0);
        bus.rmq_ready_i[i] = (q_cnt[i] < QD);
      end
      bus.rmq_read_done_i = (m_serving >= 0) && yumi && (q_cnt[m_serving] == 1);

      any = 1'b0; g = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (m_pend[(m_ptr + k) % N]) begin any = 1'b1; g = (m_ptr + k) % N; end
      end
      e_enq_ready = 1'b0; e_rmq_v = 1'b0; e_wnr = 1'b0; e_id = 2'd0;
      e_serve_v = 1'b0; e_serve_id = 2'd0; e_yumi = 1'b0; sw = 1'b0;
      e_busy = (m_serving >= 0);
      if (e_busy) begin
        e_serve_v = 1'b1; e_serve_id = 2'(m_serving); e_yumi = yumi; e_id = 2'(m_serving);
      end else begin
        elig = bus.enq_v_i && (q_cnt[bus.enq_id_i] < QD) && !m_pend[bus.enq_id_i];
        sw = any && (!elig || (Guard && m_cnt == L));
        e_enq_ready = elig && !sw;
        e_rmq_v = e_enq_ready || (sw && q_cnt[g] > 0);
        e_wnr = e_enq_ready;
        e_id = e_enq_ready ? bus.enq_id_i : 2'(g);
      end
      for (int i = 0; i < N; i++) pv[i] = m_pend[i];
      id_care = e_rmq_v || e_busy;

      @(negedge clk);
      exp_v = {e_enq_ready, e_rmq_v, e_rmq_v ? e_wnr : 1'b0, id_care ? e_id : 2'd0,
               e_serve_v, e_serve_v ? e_serve_id : 2'd0, e_yumi, e_busy, pv,
               m_rel_v, m_rel_v ? 2'(m_rel_id) : 2'd0};
      act_v = {bus.enq_ready_o, bus.rmq_v_o, e_rmq_v ? bus.rmq_write_not_read_o : 1'b0,
               id_care ? bus.rmq_mshr_id_o : 2'd0, bus.serve_v_o,
               e_serve_v ? bus.serve_id_o : 2'd0, bus.rmq_yumi_o, bus.busy_o,
               bus.pending_o, bus.release_v_o, m_rel_v ? bus.release_id_o : 2'd0};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        if (prints < 20) begin
          prints++;
          $display("FAIL random_cycle%0d: got %b want %b", c, act_v, exp_v);
        end
      end

      @(posedge clk);
      retire = -1;
      if (m_serving >= 0) begin
        if (yumi) q_cnt[m_serving]--;
        if (bus.rmq_read_done_i) begin retire = m_serving; m_serving = -1; end
      end else if (sw) begin
        m_ptr = (g + 1) % N;
        if (q_cnt[g] > 0) m_serving = g;
        else retire = g;
        m_cnt = 0;
      end else if (e_enq_ready) begin
        q_cnt[bus.enq_id_i]++;
        if (any && m_cnt < L) m_cnt++;
      end
      if (retire >= 0) m_pend[retire] = 1'b0;
      if (bus.fill_done_v_i) m_pend[bus.fill_done_id_i] = 1'b1;
      m_rel_v  = (retire >= 0);
      m_rel_id = (retire >= 0) ? retire : 0;
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    test_reset();
    test_single_serve();
    test_rr_order();
    test_empty_retire();
    test_enq_holdoff();
    test_enq_priority();
    test_reset_mid_serve();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
